// File: rtl/home_pkg.sv
// Shared types and defaults for the appliance sequencer.
package home_pkg;

   localparam logic [1:0] FAN_OFF = 2'd0;
   localparam logic [1:0] FAN_LO  = 2'd1;
   localparam logic [1:0] FAN_MED = 2'd2;
   localparam logic [1:0] FAN_HI  = 2'd3;

   localparam logic [3:0] TEMP_IDLE_DEF  = 4'd13;
   localparam logic [3:0] AC_DELTA_DEF   = 4'd2;
   localparam logic [3:0] LIGHT_IDLE_DEF = 4'd5;
   localparam logic [3:0] LIGHT_HYST_DEF = 4'd1;
   localparam int         STAGGER_CYC_DEF = 4;
   localparam int         DWELL_CYC_DEF   = 16;

   typedef enum logic {
      ARB_IDLE,
      ARB_STAGGER
   } arb_state_t;

   typedef enum logic [1:0] {
      AC_OFF,
      AC_ON_DWELL,
      AC_ON,
      AC_OFF_DWELL
   } ac_state_t;

   // Fan speed from the temperature excess over idle; 5-bit so nothing wraps.
   function automatic logic [1:0] fan_level(input logic [4:0] t, input logic [4:0] idle);
      logic [4:0] d;
      logic [1:0] lvl;
      d   = t - idle;
      lvl = FAN_HI;
      if (t <= idle)
         lvl = FAN_OFF;
      else if (d <= 5'd2)
         lvl = FAN_LO;
      else if (d <= 5'd4)
         lvl = FAN_MED;
      return lvl;
   endfunction

endpackage

// File: rtl/load_dwell_timer.sv
// Loadable down-counter that parks at zero and flags it.
module load_dwell_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Load takes priority; otherwise count down and hold at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - W'(1);
   end

   assign zero = (count == '0);

endmodule

// File: rtl/appliance_sequencer.sv
// Appliance sequencer: hysteretic requests from sensor samples, staggered
// start-ups, AC compressor dwell, and lock-out while the house is locked.
//
// Arbiter FSM
//   state        | meaning
//   ARB_IDLE     | no window open, a pending start may be granted
//   ARB_STAGGER  | window open after a start; grants only on the expiry edge
//
// AC FSM
//   state        | meaning
//   AC_OFF       | compressor off, free to start
//   AC_ON_DWELL  | compressor just started, must stay on until dwell expires
//   AC_ON        | compressor on, free to stop
//   AC_OFF_DWELL | compressor just stopped, must stay off until dwell expires
module appliance_sequencer
   import home_pkg::*;
#(
   parameter logic [3:0] TEMP_IDLE   = TEMP_IDLE_DEF,
   parameter logic [3:0] AC_DELTA    = AC_DELTA_DEF,
   parameter logic [3:0] LIGHT_IDLE  = LIGHT_IDLE_DEF,
   parameter logic [3:0] LIGHT_HYST  = LIGHT_HYST_DEF,
   parameter int         STAGGER_CYC = STAGGER_CYC_DEF,
   parameter int         DWELL_CYC   = DWELL_CYC_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [3:0] temp,
   input  logic [3:0] light_lvl,
   input  logic       unlocked,
   output logic [1:0] fan_speed,
   output logic       light_on,
   output logic       ac_on,
   output logic       stagger_busy
);

   localparam int SW = (STAGGER_CYC > 1) ? $clog2(STAGGER_CYC) : 1;
   localparam int DW = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;

   localparam logic [4:0] TEMP_IDLE5 = {1'b0, TEMP_IDLE};
   localparam logic [4:0] AC_ON_TH   = {1'b0, TEMP_IDLE} + {1'b0, AC_DELTA};
   localparam logic [4:0] LIGHT_ON5  = {1'b0, LIGHT_IDLE};
   localparam logic [4:0] LIGHT_OFF5 = {1'b0, LIGHT_IDLE} + {1'b0, LIGHT_HYST};

   logic [1:0] fan_req;
   logic       ac_req;
   logic       light_req;

   logic [1:0] eff_fan;
   logic       eff_ac;
   logic       eff_light;

   arb_state_t arb_state;
   ac_state_t  ac_state;

   logic stagger_zero;
   logic dwell_zero;
   logic arb_open;
   logic ac_start_req;
   logic fan_start_req;
   logic light_start_req;
   logic grant_ac;
   logic grant_fan;
   logic grant_light;
   logic any_grant;
   logic ac_stop;
   logic dwell_load;

   logic [4:0] temp5;
   logic [4:0] light5;

   assign temp5  = {1'b0, temp};
   assign light5 = {1'b0, light_lvl};

   // Request registers follow the sensors only on valid samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fan_req   <= FAN_OFF;
         ac_req    <= 1'b0;
         light_req <= 1'b0;
      end else if (sample_valid) begin
         fan_req <= fan_level(temp5, TEMP_IDLE5);
         if (temp5 >= AC_ON_TH)
            ac_req <= 1'b1;
         else if (temp5 <= TEMP_IDLE5)
            ac_req <= 1'b0;
         if (light5 < LIGHT_ON5)
            light_req <= 1'b1;
         else if (light5 >= LIGHT_OFF5)
            light_req <= 1'b0;
      end
   end

   // Lock masks requests without disturbing the stored request state.
   always_comb begin
      eff_fan   = unlocked ? fan_req : FAN_OFF;
      eff_ac    = unlocked & ac_req;
      eff_light = unlocked & light_req;
   end

   // Start/stop decode and fixed-priority grant (AC > fan > light).
   // The dwell and stagger expiry edges behave as the state being entered,
   // so AC transitions land exactly DWELL_CYC edges apart and consecutive
   // grants exactly STAGGER_CYC edges apart.
   always_comb begin
      arb_open        = (arb_state == ARB_IDLE) || stagger_zero;
      ac_start_req    = eff_ac &&
                        ((ac_state == AC_OFF) || ((ac_state == AC_OFF_DWELL) && dwell_zero));
      fan_start_req   = (fan_speed == FAN_OFF) && (eff_fan != FAN_OFF);
      light_start_req = !light_on && eff_light;
      grant_ac        = arb_open && ac_start_req;
      grant_fan       = arb_open && !ac_start_req && fan_start_req;
      grant_light     = arb_open && !ac_start_req && !fan_start_req && light_start_req;
      any_grant       = grant_ac || grant_fan || grant_light;
      ac_stop         = !eff_ac &&
                        ((ac_state == AC_ON) || ((ac_state == AC_ON_DWELL) && dwell_zero));
      dwell_load      = grant_ac || ac_stop;
   end

   load_dwell_timer #(.W(SW)) u_stagger_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (any_grant),
      .load_val (SW'(STAGGER_CYC - 1)),
      .zero     (stagger_zero)
   );

   load_dwell_timer #(.W(DW)) u_dwell_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (dwell_load),
      .load_val (DW'(DWELL_CYC - 1)),
      .zero     (dwell_zero)
   );

   // Arbiter FSM with the fan and light drives; stops and speed changes bypass the window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arb_state    <= ARB_IDLE;
         stagger_busy <= 1'b0;
         fan_speed    <= FAN_OFF;
         light_on     <= 1'b0;
      end else begin
         case (arb_state)
            ARB_IDLE: begin
               if (any_grant) begin
                  arb_state    <= ARB_STAGGER;
                  stagger_busy <= 1'b1;
               end
            end
            ARB_STAGGER: begin
               if (stagger_zero && !any_grant) begin
                  arb_state    <= ARB_IDLE;
                  stagger_busy <= 1'b0;
               end
            end
            default: begin
               arb_state    <= ARB_IDLE;
               stagger_busy <= 1'b0;
            end
         endcase

         if (fan_speed != FAN_OFF)
            fan_speed <= eff_fan;
         else if (grant_fan)
            fan_speed <= eff_fan;

         if (light_on && !eff_light)
            light_on <= 1'b0;
         else if (grant_light)
            light_on <= 1'b1;
      end
   end

   // AC compressor FSM enforcing the minimum on/off dwell.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ac_state <= AC_OFF;
         ac_on    <= 1'b0;
      end else begin
         case (ac_state)
            AC_OFF: begin
               if (grant_ac) begin
                  ac_state <= AC_ON_DWELL;
                  ac_on    <= 1'b1;
               end
            end
            AC_ON_DWELL: begin
               if (ac_stop) begin
                  ac_state <= AC_OFF_DWELL;
                  ac_on    <= 1'b0;
               end else if (dwell_zero) begin
                  ac_state <= AC_ON;
               end
            end
            AC_ON: begin
               if (ac_stop) begin
                  ac_state <= AC_OFF_DWELL;
                  ac_on    <= 1'b0;
               end
            end
            AC_OFF_DWELL: begin
               if (grant_ac) begin
                  ac_state <= AC_ON_DWELL;
                  ac_on    <= 1'b1;
               end else if (dwell_zero) begin
                  ac_state <= AC_OFF;
               end
            end
            default: begin
               ac_state <= AC_OFF;
               ac_on    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_appliance_sequencer.sv
// Directed bench for appliance_sequencer at its default thresholds.
// Edge numbers in comments count rising edges from the first sample edge.
module tb_appliance_sequencer;

   logic       clk;
   logic       rst;
   logic       sample_valid;
   logic [3:0] temp;
   logic [3:0] light_lvl;
   logic       unlocked;
   logic [1:0] fan_speed;
   logic       light_on;
   logic       ac_on;
   logic       stagger_busy;

   int nchk;
   int nerr;

   appliance_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .sample_valid (sample_valid),
      .temp         (temp),
      .light_lvl    (light_lvl),
      .unlocked     (unlocked),
      .fan_speed    (fan_speed),
      .light_on     (light_on),
      .ac_on        (ac_on),
      .stagger_busy (stagger_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges and park on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_sample(input logic [3:0] t, input logic [3:0] l);
      temp         = t;
      light_lvl    = l;
      sample_valid = 1'b1;
      step(1);
      sample_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst          = 1'b1;
      sample_valid = 1'b0;
      unlocked     = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; sample_valid = 1'b0; temp = 4'd15; light_lvl = 4'd0; unlocked = 1'b1;
      step(2);
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL reset_fan: got %0d expected 0", fan_speed); end
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL reset_light: got %0b expected 0", light_on); end
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL reset_ac: got %0b expected 0", ac_on); end
      nchk++; if (stagger_busy !== 1'b0) begin nerr++; $display("FAIL reset_busy: got %0b expected 0", stagger_busy); end
      rst = 1'b0;
   endtask

   task automatic test_startup();
      apply_reset();
      do_sample(4'd15, 4'd2);                               // e1
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL start_ac_e1: got %0b expected 0", ac_on); end
      step(1);                                              // e2
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL start_ac_e2: got %0b expected 1", ac_on); end
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL start_fan_e2: got %0d expected 0", fan_speed); end
      nchk++; if (stagger_busy !== 1'b1) begin nerr++; $display("FAIL start_busy_e2: got %0b expected 1", stagger_busy); end
      step(3);                                              // e5
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL start_fan_e5: got %0d expected 0", fan_speed); end
      nchk++; if (stagger_busy !== 1'b1) begin nerr++; $display("FAIL start_busy_e5: got %0b expected 1", stagger_busy); end
      step(1);                                              // e6
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL start_fan_e6: got %0d expected 1", fan_speed); end
      step(3);                                              // e9
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL start_light_e9: got %0b expected 0", light_on); end
      step(1);                                              // e10
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL start_light_e10: got %0b expected 1", light_on); end
      step(4);                                              // e14
      nchk++; if (stagger_busy !== 1'b0) begin nerr++; $display("FAIL start_busy_e14: got %0b expected 0", stagger_busy); end
   endtask

   task automatic test_ac_dwell();
      apply_reset();
      do_sample(4'd15, 4'd9);                               // e1
      step(1);                                              // e2 AC rises
      step(4);                                              // e6 fan starts
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL dwell_fan_e6: got %0d expected 1", fan_speed); end
      do_sample(4'd13, 4'd9);                               // e7
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL dwell_fan_e7: got %0d expected 1", fan_speed); end
      step(1);                                              // e8
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL dwell_fan_e8: got %0d expected 0", fan_speed); end
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL dwell_ac_e8: got %0b expected 1", ac_on); end
      step(9);                                              // e17
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL dwell_ac_e17: got %0b expected 1", ac_on); end
      step(1);                                              // e18
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL dwell_ac_e18: got %0b expected 0", ac_on); end
      do_sample(4'd15, 4'd9);                               // e19
      step(14);                                             // e33
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL dwell_ac_e33: got %0b expected 0", ac_on); end
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL dwell_fan_e33: got %0d expected 1", fan_speed); end
      step(1);                                              // e34
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL dwell_ac_e34: got %0b expected 1", ac_on); end
   endtask

   task automatic test_light_hyst();
      apply_reset();
      do_sample(4'd10, 4'd2);                               // e1
      step(1);                                              // e2
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL hyst_on_e2: got %0b expected 1", light_on); end
      do_sample(4'd10, 4'd5);                               // e3
      step(1);                                              // e4
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL hyst_lvl5_hold: got %0b expected 1", light_on); end
      light_lvl = 4'd9;
      step(2);                                              // e6, no valid sample
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL hyst_no_valid: got %0b expected 1", light_on); end
      do_sample(4'd10, 4'd6);                               // e7
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL hyst_lvl6_e7: got %0b expected 1", light_on); end
      step(1);                                              // e8
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL hyst_lvl6_off: got %0b expected 0", light_on); end
      do_sample(4'd10, 4'd5);                               // e9
      step(1);                                              // e10
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL hyst_lvl5_stay_off: got %0b expected 0", light_on); end
      do_sample(4'd10, 4'd4);                               // e11
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL hyst_lvl4_e11: got %0b expected 0", light_on); end
      step(1);                                              // e12
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL hyst_lvl4_on: got %0b expected 1", light_on); end
      nchk++; if (stagger_busy !== 1'b1) begin nerr++; $display("FAIL hyst_busy_e12: got %0b expected 1", stagger_busy); end
   endtask

   task automatic test_stop_in_window();
      apply_reset();
      do_sample(4'd14, 4'd2);                               // e1
      step(1);                                              // e2 fan wins over light
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL win_fan_e2: got %0d expected 1", fan_speed); end
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL win_light_e2: got %0b expected 0", light_on); end
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL win_ac_e2: got %0b expected 0", ac_on); end
      do_sample(4'd13, 4'd9);                               // e3
      step(1);                                              // e4
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL win_fan_stop: got %0d expected 0", fan_speed); end
      nchk++; if (stagger_busy !== 1'b1) begin nerr++; $display("FAIL win_busy_e4: got %0b expected 1", stagger_busy); end
      step(2);                                              // e6
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL win_light_dropped: got %0b expected 0", light_on); end
      nchk++; if (stagger_busy !== 1'b0) begin nerr++; $display("FAIL win_busy_e6: got %0b expected 0", stagger_busy); end
   endtask

   task automatic test_lock();
      apply_reset();
      do_sample(4'd15, 4'd2);                               // e1
      step(9);                                              // e10
      nchk++; if ({ac_on, fan_speed, light_on} !== 4'b1011) begin nerr++; $display("FAIL lock_all_on: got %b expected 1011", {ac_on, fan_speed, light_on}); end
      step(1);                                              // e11
      unlocked = 1'b0;
      step(1);                                              // e12
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL lock_fan_off: got %0d expected 0", fan_speed); end
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL lock_light_off: got %0b expected 0", light_on); end
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL lock_ac_e12: got %0b expected 1", ac_on); end
      step(5);                                              // e17
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL lock_ac_e17: got %0b expected 1", ac_on); end
      step(1);                                              // e18
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL lock_ac_e18: got %0b expected 0", ac_on); end
      step(16);                                             // e34
      unlocked = 1'b1;
      step(1);                                              // e35
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL unlock_ac_e35: got %0b expected 1", ac_on); end
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL unlock_fan_e35: got %0d expected 0", fan_speed); end
      step(3);                                              // e38
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL unlock_fan_e38: got %0d expected 0", fan_speed); end
      step(1);                                              // e39
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL unlock_fan_e39: got %0d expected 1", fan_speed); end
      step(3);                                              // e42
      nchk++; if (light_on !== 1'b0) begin nerr++; $display("FAIL unlock_light_e42: got %0b expected 0", light_on); end
      step(1);                                              // e43
      nchk++; if (light_on !== 1'b1) begin nerr++; $display("FAIL unlock_light_e43: got %0b expected 1", light_on); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      do_sample(4'd15, 4'd2);                               // e1
      step(2);                                              // e3, mid-window and mid-dwell
      nchk++; if (ac_on !== 1'b1) begin nerr++; $display("FAIL mid_ac_pre: got %0b expected 1", ac_on); end
      #2 rst = 1'b1;
      #1;
      nchk++; if ({ac_on, fan_speed, light_on, stagger_busy} !== 5'b0) begin nerr++; $display("FAIL mid_async_clear: got %b expected 00000", {ac_on, fan_speed, light_on, stagger_busy}); end
      @(negedge clk);
      rst = 1'b0;
      step(2);
      nchk++; if ({ac_on, fan_speed, light_on} !== 4'b0) begin nerr++; $display("FAIL mid_req_cleared: got %b expected 0000", {ac_on, fan_speed, light_on}); end
      do_sample(4'd14, 4'd9);                               // e1'
      nchk++; if (fan_speed !== 2'd0) begin nerr++; $display("FAIL mid_fan_e1: got %0d expected 0", fan_speed); end
      step(1);                                              // e2'
      nchk++; if (fan_speed !== 2'd1) begin nerr++; $display("FAIL mid_fan_e2: got %0d expected 1", fan_speed); end
      nchk++; if (stagger_busy !== 1'b1) begin nerr++; $display("FAIL mid_busy_e2: got %0b expected 1", stagger_busy); end
      nchk++; if (ac_on !== 1'b0) begin nerr++; $display("FAIL mid_ac_e2: got %0b expected 0", ac_on); end
   endtask

   initial begin
      nchk = 0;
      nerr = 0;
      test_reset();
      test_startup();
      test_ac_dwell();
      test_light_hyst();
      test_stop_in_window();
      test_lock();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
      $finish;
   end

endmodule
